multdiv_sequencer: RTL and testbench
====================================

Name: multdiv_sequencer

Overview:
- Control FSM for the iterative multiply/divide unit of the MIPS datapath.
- Sequences the operand, partial-result and result 32-bit registers by driving their enables:
  - one load cycle;
  - STEPS shift/add (or shift/subtract) cycles;
  - a one-cycle completion pulse with optional divide-by-zero exception.
- Also supplies the busy level used to hold the pipeline-register enables while an operation is in flight.

Parameters:
STEPS, 32, number of iteration cycles per operation (one per result bit)
CW, 5, counter width; must satisfy 2^CW >= STEPS

Ports:
clk  input  1  rising-edge clock
clr  input  1  reset; synchronous, active-low (clr=0 at a clk rising edge resets the block)
ctrl_mult  input  1  start-multiply request, single-cycle pulse from decode
ctrl_div  input  1  start-divide request, single-cycle pulse from decode
divisor_zero  input  1  combinational flag from datapath: incoming operand B == 0, valid in the start cycle
load_en  output  1  enable for the operand/partial-result registers: capture operands at this edge
step_en  output  1  enable for one iteration of the shift/add/subtract datapath
is_div  output  1  latched operation select: 0 = multiply, 1 = divide
result_en  output  1  enable for the 32-bit result register
data_ready  output  1  one-cycle completion pulse
data_exception  output  1  divide-by-zero flag; valid only while data_ready=1
busy  output  1  high while an operation is in flight; drives the pipeline stall
count  output  CW  iteration index, for datapath bit selection

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (clr=0 at an edge, from any state, including mid-RUN):
  - next state IDLE; count=0; is_div=0;
  - load_en, step_en, result_en, data_ready, data_exception and busy all 0;
  - an in-flight operation is discarded with no data_ready.
- IDLE:
  - busy=0, step_en=0, result_en=0.
  - load_en = ctrl_mult | ctrl_div, combinational in the same cycle, so operand registers capture at the same edge the FSM leaves IDLE.
  - Start with ctrl_mult=1: is_div<=0, count<=0, next RUN.
  - Start with ctrl_div=1 and ctrl_mult=0, divisor_zero=0: is_div<=1, count<=0, next RUN.
  - Start with ctrl_div=1, ctrl_mult=0, divisor_zero=1: is_div<=1, next DONE directly (no iterations); data_exception<=1.
  - ctrl_mult and ctrl_div both 1: multiply wins; ctrl_div is ignored and divisor_zero is not examined.
- RUN:
  - busy=1, step_en=1, load_en=0.
  - Each edge: count<=count+1.
  - result_en=1 only when count==STEPS-1; next state at that edge is DONE.
  - All ctrl_mult/ctrl_div pulses are ignored (no queueing, no restart).
- DONE:
  - data_ready=1 for exactly one cycle; data_exception as latched; busy=0; step_en=0; result_en=0.
  - Next state IDLE unconditionally; count<=0; data_exception<=0 at exit.
  - A ctrl pulse arriving in DONE is ignored and must be re-issued by the pipeline.
- Latency: start edge at cycle 0 → RUN during cycles 1..STEPS → data_ready high in cycle STEPS+1 (33 cycles with defaults). Divide-by-zero: data_ready in cycle 1.
- Back-to-back: earliest next accepted start is the cycle after DONE, in IDLE.
- Outputs are decoded from registered state/count only; load_en is the sole output depending combinationally on inputs.
- count never exceeds STEPS-1 and does not wrap within an operation.

Test Plan:
- Reset: hold clr=0 for 2 cycles with ctrl_mult=1 → all outputs 0, state IDLE, count=0; release clr and pulse nothing → outputs stay 0.
- Multiply: ctrl_mult pulse at cycle 0 →
  - load_en=1 in cycle 0;
  - busy=1 and step_en=1 in cycles 1..32, count 0..31;
  - result_en=1 only in cycle 32;
  - data_ready=1 and is_div=0, data_exception=0 in cycle 33;
  - busy=0 in cycle 33.
- Divide by zero: ctrl_div=1, divisor_zero=1 at cycle 0 → load_en=1 in cycle 0; data_ready=1, data_exception=1, is_div=1 in cycle 1; step_en and result_en never asserted; data_exception=0 in cycle 2.
- Collisions:
  - ctrl_mult=ctrl_div=1 at cycle 0 → is_div=0, normal 33-cycle multiply.
  - ctrl_div pulse at cycle 10 of that run → ignored; single data_ready at cycle 33.
  - ctrl_mult pulse in the DONE cycle → ignored; no load_en.
- Abort: ctrl_div (divisor_zero=0) at cycle 0, clr=0 at cycle 15 → IDLE at cycle 16, count=0, busy=0; no data_ready ever; a fresh ctrl_mult at cycle 17 completes with data_ready at cycle 50.
- Back-to-back: ctrl_mult at cycle 0, ctrl_div at cycle 34 (first IDLE cycle) → two data_ready pulses at cycles 33 and 67; is_div 0 then 1.

Source files
------------

// File: rtl/multdiv_sequencer_if.sv
// ---------------------------------------------------------------------------
// multdiv_sequencer_if
//   Handshake bundle between the decode/datapath side and the iterative
//   multiply/divide control sequencer.
//
//   Requests (decode/datapath -> sequencer):
//     ctrl_mult      start-multiply pulse
//     ctrl_div       start-divide pulse
//     divisor_zero   operand B == 0, valid in the start cycle
//   Controls (sequencer -> datapath/pipeline):
//     load_en        capture operands at this edge
//     step_en        perform one shift/add or shift/subtract iteration
//     is_div         latched operation select (0 = multiply, 1 = divide)
//     result_en      capture the final result
//     data_ready     one-cycle completion pulse
//     data_exception divide-by-zero flag, meaningful with data_ready
//     busy           operation in flight, holds the pipeline
//     count          iteration index for datapath bit selection
//
//   master : the pipeline/datapath side
//   slave  : the sequencer
// ---------------------------------------------------------------------------
interface multdiv_sequencer_if #(
  parameter int CW = 5
);
  logic          ctrl_mult;
  logic          ctrl_div;
  logic          divisor_zero;
  logic          load_en;
  logic          step_en;
  logic          is_div;
  logic          result_en;
  logic          data_ready;
  logic          data_exception;
  logic          busy;
  logic [CW-1:0] count;

  modport master (
    output ctrl_mult, ctrl_div, divisor_zero,
    input  load_en, step_en, is_div, result_en,
    input  data_ready, data_exception, busy, count
  );

  modport slave (
    input  ctrl_mult, ctrl_div, divisor_zero,
    output load_en, step_en, is_div, result_en,
    output data_ready, data_exception, busy, count
  );
endinterface

// File: rtl/multdiv_sequencer.sv
// ---------------------------------------------------------------------------
// multdiv_sequencer
//   Control FSM for the iterative 32-bit multiply/divide unit.  An accepted
//   start loads the operands (load_en, same cycle as the request), then runs
//   STEPS iteration cycles (step_en, count = 0..STEPS-1, result_en on the
//   last one), then raises data_ready for one cycle.  A divide whose
//   divisor is zero skips the iterations and completes the next cycle with
//   data_exception set.
//
//   Parameters:
//     STEPS  iteration cycles per operation (one per result bit)
//     CW     counter width, 2**CW >= STEPS
//
//   Ports:
//     clk    rising-edge clock
//     clr    synchronous active-low reset; aborts any operation in flight
//     bus    multdiv_sequencer_if.slave (requests in, controls out)
//
//   Every output except load_en comes straight from a register, so the
//   pipeline sees clean levels.  load_en is combinational from the request
//   so the operand registers capture on the same edge the FSM leaves IDLE.
// ---------------------------------------------------------------------------
module multdiv_sequencer #(
  parameter int STEPS = 32,
  parameter int CW    = 5
) (
  input  logic                clk,
  input  logic                clr,
  multdiv_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST  = CW'(STEPS - 1);
  localparam logic [CW-1:0] ONE   = CW'(1);

  state_t        state_reg;
  logic [CW-1:0] count_reg;
  logic          is_div_reg;
  logic          busy_reg;
  logic          step_en_reg;
  logic          result_en_reg;
  logic          data_ready_reg;
  logic          data_exception_reg;

  // A request is only accepted while idle and out of reset; pulses that
  // arrive in RUN or DONE are dropped and must be re-issued.
  logic start;
  assign start = clr && (state_reg == IDLE) && (bus.ctrl_mult || bus.ctrl_div);

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_reg          <= IDLE;
      count_reg          <= '0;
      is_div_reg         <= 1'b0;
      busy_reg           <= 1'b0;
      step_en_reg        <= 1'b0;
      result_en_reg      <= 1'b0;
      data_ready_reg     <= 1'b0;
      data_exception_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.ctrl_mult) begin
            // Multiply wins over a simultaneous divide request.
            is_div_reg    <= 1'b0;
            count_reg     <= '0;
            state_reg     <= RUN;
            busy_reg      <= 1'b1;
            step_en_reg   <= 1'b1;
            result_en_reg <= (LAST == '0);
          end else if (bus.ctrl_div) begin
            is_div_reg <= 1'b1;
            count_reg  <= '0;
            if (bus.divisor_zero) begin
              // No iterations: report the exception on the next cycle.
              state_reg          <= DONE;
              data_ready_reg     <= 1'b1;
              data_exception_reg <= 1'b1;
            end else begin
              state_reg     <= RUN;
              busy_reg      <= 1'b1;
              step_en_reg   <= 1'b1;
              result_en_reg <= (LAST == '0);
            end
          end
        end

        RUN: begin
          if (count_reg == LAST) begin
            // Last iteration: the result register captured at this edge.
            // count returns to 0 here instead of stepping past STEPS-1.
            state_reg      <= DONE;
            count_reg      <= '0;
            busy_reg       <= 1'b0;
            step_en_reg    <= 1'b0;
            result_en_reg  <= 1'b0;
            data_ready_reg <= 1'b1;
          end else begin
            count_reg     <= count_reg + ONE;
            // Look ahead so result_en is a register aligned to count==LAST.
            result_en_reg <= ((count_reg + ONE) == LAST);
          end
        end

        DONE: begin
          state_reg          <= IDLE;
          count_reg          <= '0;
          data_ready_reg     <= 1'b0;
          data_exception_reg <= 1'b0;
        end

        default: begin
          state_reg          <= IDLE;
          count_reg          <= '0;
          busy_reg           <= 1'b0;
          step_en_reg        <= 1'b0;
          result_en_reg      <= 1'b0;
          data_ready_reg     <= 1'b0;
          data_exception_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.load_en        = start;
  assign bus.step_en        = step_en_reg;
  assign bus.is_div         = is_div_reg;
  assign bus.result_en      = result_en_reg;
  assign bus.data_ready     = data_ready_reg;
  assign bus.data_exception = data_exception_reg;
  assign bus.busy           = busy_reg;
  assign bus.count          = count_reg;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// ---------------------------------------------------------------------------
// tb_multdiv_sequencer
//   Stimulus drives requests one cycle at a time and feeds a timeline model:
//   each accepted operation paints its expected busy/step/result/count
//   window into per-cycle arrays and pushes its completion into a queue.
//   A separate monitor compares the outputs every cycle and pops the queue
//   on every data_ready.
// ---------------------------------------------------------------------------
module tb_multdiv_sequencer;
  localparam int STEPS = 32;
  localparam int CW    = 5;
  localparam int MAXC  = 4096;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  multdiv_sequencer_if #(.CW(CW)) bus ();

  multdiv_sequencer #(.STEPS(STEPS), .CW(CW)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected per-cycle timeline.
  bit exp_load  [MAXC];
  bit exp_busy  [MAXC];
  bit exp_step  [MAXC];
  bit exp_res   [MAXC];
  bit exp_rdy   [MAXC];
  bit exp_exc   [MAXC];
  bit exp_isdiv [MAXC];
  int exp_cnt   [MAXC];

  typedef struct {
    int cycle;
    bit div;
    bit exc;
  } resp_t;
  resp_t sbq[$];

  int next_free = 0;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic model_cycle(input int c, input bit m, input bit d, input bit dz, input bit rn);
    bit opdiv;
    bit z;
    int rdy;
    if (!rn) begin
      // Reset at the end of cycle c wipes everything scheduled after it.
      for (int i = c + 1; i < MAXC; i++) begin
        exp_load[i] = 0; exp_busy[i] = 0; exp_step[i] = 0; exp_res[i] = 0;
        exp_rdy[i] = 0; exp_exc[i] = 0; exp_isdiv[i] = 0; exp_cnt[i] = 0;
      end
      while (sbq.size() > 0 && sbq[$].cycle > c) void'(sbq.pop_back());
      next_free = c + 1;
    end else if ((m || d) && c >= next_free) begin
      opdiv = !m;
      z     = opdiv && dz;
      rdy   = z ? c + 1 : c + STEPS + 1;
      exp_load[c] = 1;
      if (!z) begin
        for (int k = 1; k <= STEPS; k++) begin
          exp_busy[c+k] = 1;
          exp_step[c+k] = 1;
          exp_cnt[c+k]  = k - 1;
        end
        exp_res[c+STEPS] = 1;
      end
      exp_rdy[rdy] = 1;
      exp_exc[rdy] = z;
      for (int i = c + 1; i < MAXC; i++) exp_isdiv[i] = opdiv;
      sbq.push_back('{rdy, opdiv, z});
      next_free = rdy + 1;
    end
  endtask

  task automatic drive(input bit m, input bit d, input bit dz, input bit rn);
    @(posedge clk);
    #1;
    bus.ctrl_mult    = m;
    bus.ctrl_div     = d;
    bus.divisor_zero = dz;
    clr              = rn;
    model_cycle(cyc, m, d, dz, rn);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 1);
  endtask

  // Monitor: per-cycle output check plus scoreboard pop on completion.
  logic [7+CW-1:0] got_vec;
  logic [7+CW-1:0] exp_vec;
  logic [CW-1:0]   exp_cnt_w;
  resp_t           r;

  always @(negedge clk) begin
    if (cyc >= 1 && cyc < MAXC) begin
      exp_cnt_w = exp_cnt[cyc][CW-1:0];
      got_vec = {bus.load_en, bus.busy, bus.step_en, bus.result_en,
                 bus.data_ready, bus.data_exception, bus.is_div, bus.count};
      exp_vec = {exp_load[cyc], exp_busy[cyc], exp_step[cyc], exp_res[cyc],
                 exp_rdy[cyc], exp_exc[cyc], exp_isdiv[cyc], exp_cnt_w};
      n_cmp++;
      if (got_vec !== exp_vec) begin
        n_bad++;
        $display("FAIL outputs cycle %0d: got load/busy/step/res/rdy/exc/isdiv/count=%b expected %b",
                 cyc, got_vec, exp_vec);
      end
      if (bus.data_ready === 1'b1) begin
        n_cmp++;
        if (sbq.size() == 0) begin
          n_bad++;
          $display("FAIL completion cycle %0d: got unexpected data_ready, expected none", cyc);
        end else begin
          r = sbq.pop_front();
          if (r.cycle != cyc || r.div !== bus.is_div || r.exc !== bus.data_exception) begin
            n_bad++;
            $display("FAIL completion: got cycle=%0d is_div=%b exc=%b expected cycle=%0d is_div=%b exc=%b",
                     cyc, bus.is_div, bus.data_exception, r.cycle, r.div, r.exc);
          end else begin
            $display("txn done cycle=%0d is_div=%b exc=%b", cyc, r.div, r.exc);
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no end of stimulus, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Cycle 0 and 1: reset held with a multiply request present.
    clr = 1'b0;
    bus.ctrl_mult = 1'b1;
    bus.ctrl_div = 1'b0;
    bus.divisor_zero = 1'b0;
    model_cycle(0, 1, 0, 0, 0);
    drive(1, 0, 0, 0);
    idle(3);

    // Collision start, divide mid-run, multiply in the DONE cycle,
    // then a back-to-back divide in the first idle cycle.
    drive(1, 1, 1, 1);
    idle(9);
    drive(0, 1, 0, 1);
    idle(22);
    drive(1, 0, 0, 1);
    drive(0, 1, 0, 1);
    idle(36);

    // Divide by zero.
    drive(0, 1, 1, 1);
    idle(4);

    // Abort a divide with reset at cycle 15, fresh multiply at cycle 17.
    drive(0, 1, 0, 1);
    idle(14);
    drive(0, 0, 0, 0);
    idle(1);
    drive(1, 0, 0, 1);
    idle(40);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom_range(7) == 0), ($urandom_range(7) == 0),
            ($urandom_range(2) == 0), ($urandom_range(149) != 0));
    end
    idle(40);

    @(negedge clk);
    #1;
    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d completions outstanding, expected 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
